// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, instruction memory and decode.
// The sequencer is the slave; memory/decode/control drive the master side.
interface pc_sequencer_if #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned INS_W = 32,
   parameter int unsigned CNT_W = 16
);
   logic [PC_W-1:0]  pc;
   logic [INS_W-1:0] ins_in;
   logic             stall;
   logic             branch_taken;
   logic [PC_W-1:0]  branch_target;
   logic             jump;
   logic [PC_W-1:0]  jump_target;
   logic             halt_req;
   logic [INS_W-1:0] ir;
   logic [PC_W-1:0]  ir_pc;
   logic             ir_valid;
   logic             halted;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      input  pc, ir, ir_pc, ir_valid, halted, fetch_count,
      output ins_in, stall, branch_taken, branch_target, jump, jump_target, halt_req
   );

   modport slave (
      output pc, ir, ir_pc, ir_valid, halted, fetch_count,
      input  ins_in, stall, branch_taken, branch_target, jump, jump_target, halt_req
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter + IF/ID register: ir follows pc by one edge, redirects leave one bubble.
// stall freezes fetch; halt_req stops fetch until reset; all outputs are registers.
module pc_sequencer #(
   parameter int unsigned     PC_W     = 8,
   parameter int unsigned     INS_W    = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic           clk,
   input  logic           rstd,
   pc_sequencer_if.slave  bus
);
   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t           r_state, w_state;
   logic [PC_W-1:0]  r_pc, w_pc;
   logic [INS_W-1:0] r_ir, w_ir;
   logic [PC_W-1:0]  r_ir_pc, w_ir_pc;
   logic             r_ir_valid, w_ir_valid;
   logic [CNT_W-1:0] r_cnt, w_cnt;

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state;
         r_pc       <= w_pc;
         r_ir       <= w_ir;
         r_ir_pc    <= w_ir_pc;
         r_ir_valid <= w_ir_valid;
         r_cnt      <= w_cnt;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_ir       = r_ir;
      w_ir_pc    = r_ir_pc;
      w_ir_valid = r_ir_valid;
      w_cnt      = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (bus.halt_req) begin
               w_state    = ST_HALTED;
               w_ir_valid = 1'b0;
            end else if (bus.jump) begin
               // Redirects beat stall; the old-pc instruction is wrong-path and dropped.
               w_pc       = bus.jump_target;
               w_ir       = '0;
               w_ir_valid = 1'b0;
            end else if (bus.branch_taken) begin
               w_pc       = bus.branch_target;
               w_ir       = '0;
               w_ir_valid = 1'b0;
            end else if (!bus.stall) begin
               w_ir       = bus.ins_in;
               w_ir_pc    = r_pc;
               w_ir_valid = 1'b1;
               w_pc       = r_pc + PC_W'(1);
               if (r_cnt != '1) begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.pc          = r_pc;
   assign bus.ir          = r_ir;
   assign bus.ir_pc       = r_ir_pc;
   assign bus.ir_valid    = r_ir_valid;
   assign bus.halted      = (r_state == ST_HALTED);
   assign bus.fetch_count = r_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with mem[i] = i + 100 and a 4-bit fetch counter.
module tb_pc_sequencer;
   localparam int unsigned PC_W  = 8;
   localparam int unsigned INS_W = 32;
   localparam int unsigned CNT_W = 4;

   logic clk = 1'b0;
   logic rstd;
   int   checks = 0;
   int   errors = 0;
   logic [INS_W-1:0] mem [256];

   pc_sequencer_if #(.PC_W(PC_W), .INS_W(INS_W), .CNT_W(CNT_W)) sif ();

   pc_sequencer #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(8'd0), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rstd (rstd),
      .bus  (sif.slave)
   );

   always #5 clk = ~clk;

   assign sif.ins_in = mem[sif.pc];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int epc, input int eir, input int eirpc,
                          input int ev, input int eh, input int ecnt);
      chk({tag, ".pc"},          32'(sif.pc),          32'(epc));
      chk({tag, ".ir"},          sif.ir,               32'(eir));
      chk({tag, ".ir_pc"},       32'(sif.ir_pc),       32'(eirpc));
      chk({tag, ".ir_valid"},    32'(sif.ir_valid),    32'(ev));
      chk({tag, ".halted"},      32'(sif.halted),      32'(eh));
      chk({tag, ".fetch_count"}, 32'(sif.fetch_count), 32'(ecnt));
   endtask

   task automatic chk_bubble(input string tag, input int epc, input int ecnt);
      chk({tag, ".pc"},          32'(sif.pc),          32'(epc));
      chk({tag, ".ir"},          sif.ir,               32'd0);
      chk({tag, ".ir_valid"},    32'(sif.ir_valid),    32'd0);
      chk({tag, ".halted"},      32'(sif.halted),      32'd0);
      chk({tag, ".fetch_count"}, 32'(sif.fetch_count), 32'(ecnt));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
      rstd              = 1'b0;
      sif.stall         = 1'b0;
      sif.branch_taken  = 1'b0;
      sif.branch_target = '0;
      sif.jump          = 1'b0;
      sif.jump_target   = '0;
      sif.halt_req      = 1'b0;

      #2 chk_out("reset", 0, 0, 0, 0, 0, 0);
      #1 rstd = 1'b1;

      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_out("seq", k, 99 + k, k - 1, 1, 0, k);
      end

      sif.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out("stall", 5, 104, 4, 1, 0, 5);
      end
      sif.stall = 1'b0;
      tick();
      chk_out("unstall", 6, 105, 5, 1, 0, 6);

      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_out("seq2", 6 + k, 105 + k, 5 + k, 1, 0, 6 + k);
      end

      sif.branch_taken = 1'b1; sif.branch_target = 8'd40;
      sif.jump = 1'b1;         sif.jump_target   = 8'd80;
      tick();
      sif.branch_taken = 1'b0; sif.jump = 1'b0;
      chk_bubble("jump_wins", 80, 10);
      tick();
      chk_out("after_jump", 81, 180, 80, 1, 0, 11);

      sif.stall = 1'b1; sif.branch_taken = 1'b1; sif.branch_target = 8'd20;
      tick();
      sif.branch_taken = 1'b0;
      chk_bubble("br_over_stall", 20, 11);
      tick();
      chk_bubble("br_stall_hold", 20, 11);
      sif.stall = 1'b0;
      tick();
      chk_out("after_branch", 21, 120, 20, 1, 0, 12);

      sif.jump = 1'b1; sif.jump_target = 8'd5;
      tick();
      sif.jump = 1'b0;
      chk_bubble("jump5", 5, 12);
      tick();
      chk_out("pre_halt6", 6, 105, 5, 1, 0, 13);
      tick();
      chk_out("pre_halt7", 7, 106, 6, 1, 0, 14);

      sif.halt_req = 1'b1; sif.jump = 1'b1; sif.jump_target = 8'd99;
      tick();
      sif.halt_req = 1'b0;
      chk_out("halt", 7, 106, 6, 0, 1, 14);
      sif.branch_taken = 1'b1; sif.branch_target = 8'd50;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("halted_hold", 7, 106, 6, 0, 1, 14);
      end
      sif.jump = 1'b0; sif.branch_taken = 1'b0;

      #2 rstd = 1'b0;
      #1 chk_out("async_reset", 0, 0, 0, 0, 0, 0);
      rstd = 1'b1;
      tick();
      chk_out("post_reset", 1, 100, 0, 1, 0, 1);

      sif.jump = 1'b1; sif.jump_target = 8'd254;
      tick();
      sif.jump = 1'b0;
      chk_bubble("jump254", 254, 1);
      tick();
      chk_out("wrap254", 255, 354, 254, 1, 0, 2);
      tick();
      chk_out("wrap255", 0, 355, 255, 1, 0, 3);
      tick();
      chk_out("wrap0", 1, 100, 0, 1, 0, 4);

      for (int k = 0; k < 11; k++) tick();
      chk_out("cnt_max", 12, 111, 11, 1, 0, 15);
      tick();
      chk_out("cnt_sat", 13, 112, 12, 1, 0, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Upstream neighbour of the instruction fetch memory.
- Owns the program counter that addresses instruction memory, and the IF/ID instruction register that latches the memory's combinational output.
- Handles sequential advance, stall, branch/jump redirect with wrong-path squash, and a terminal halt.
- Feeds decode with instruction, its PC and a valid flag; keeps a fetched-instruction count for debug.

Parameters:
- PC_W, 8, program counter width; instruction memory depth is 2**PC_W.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstd  input  1  asynchronous active-low reset.
- pc  output  PC_W  registered address driven to the instruction memory.
- ins_in  input  INS_W  instruction returned combinationally by memory for the current pc.
- stall  input  1  hold pc and instruction register this cycle.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  PC_W  branch destination.
- jump  input  1  redirect to jump_target.
- jump_target  input  PC_W  jump destination.
- halt_req  input  1  stop fetching permanently until reset.
- ir  output  INS_W  latched instruction for decode.
- ir_pc  output  PC_W  address the ir was fetched from.
- ir_valid  output  1  ir holds a real instruction (not a bubble).
- halted  output  1  sequencer is in HALTED state.
- fetch_count  output  CNT_W  number of valid instructions latched, saturating.

Behaviour:
- Reset (rstd=0, immediate, independent of clk):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, HALTED. RUN→HALTED on halt_req. HALTED is left only by reset.
- Per rising edge in RUN, the first matching rule wins:
  1. halt_req=1: state←HALTED, halted←1, ir_valid←0; pc, ir, ir_pc hold.
  2. jump=1: pc←jump_target, ir←0, ir_valid←0 (squash the wrong-path instruction at the old pc).
  3. branch_taken=1: pc←branch_target, ir←0, ir_valid←0.
  4. stall=1: pc, ir, ir_pc, ir_valid, fetch_count all hold.
  5. Otherwise: ir←ins_in, ir_pc←pc, ir_valid←1, pc←pc+1, fetch_count+1.
- Redirect overrides stall. When jump and branch_taken are both 1, jump wins.
- HALTED: all registers hold; every input is ignored.
- Latency:
  - Instruction at address A appears on ir one edge after pc=A, provided no stall or redirect occurs at that edge.
  - After a redirect edge, the target instruction appears on ir at the next non-stalled edge, giving exactly one bubble cycle.
- pc arithmetic is modulo 2**PC_W: the increment after 255 gives 0 (PC_W=8). There is no carry-out.
- fetch_count saturates at 2**CNT_W-1 and never wraps.
- Targets are taken verbatim; there are no alignment or range checks.
- Reset asserted mid-operation, including while stalled or HALTED, restores all reset values immediately. The first edge after rstd rises performs a normal rule-5 capture at RESET_PC.
- Outputs are pure register outputs; there is no combinational path from any input to any output.

Test Plan:
- Reset release, memory[i]=i+100, no stall for 4 edges → ir: 100,101,102,103; ir_pc 0..3; pc=4; fetch_count=4; ir_valid=1 from edge 1.
- At pc=5 assert stall for 3 edges, then release → pc, ir, ir_pc, fetch_count frozen for 3 edges; the next edge resumes with ir=mem[5], pc=6.
- At pc=10 pulse branch_taken with target 40 and jump with target 80 in the same cycle → pc=80 and ir_valid=0 for one cycle; the next edge gives ir=mem[80], ir_pc=80.
- Redirect while stall=1, branch_target=20 → pc=20 regardless of stall; the bubble is inserted.
- Start at pc=254, run 3 edges → ir_pc 254,255,0; pc=1.
- Assert halt_req at pc=7, run 5 more edges → halted=1, pc=7, ir_valid=0, fetch_count frozen. Drop rstd asynchronously between edges → all outputs return to reset values before the next edge.
